usb_data_buffer: RTL and testbench
==================================

// Module: usb_data_buffer
// PURPOSE
//  64-byte single-clock FIFO data buffer shared by the USB packet path.
//  Producer (RX decoder or host write side) pushes bytes; consumer (host read side or TX encoder) pops them.
//  Tracks occupancy with an internal up/down count; exports full/empty/occupancy to the protocol controller.
//  Sticky error flags on overflow/underflow; synchronous flush between packets.
// PARAMETERS
//  DATA_W   8   width of one buffer entry (bits)
//  DEPTH    64  number of entries; power of two
//  CNT_W    7   occupancy width = $clog2(DEPTH)+1; holds 0..DEPTH
// PORTS
//  clk            in   1       system clock; all state on posedge
//  rst            in   1       synchronous, active-high reset
//  flush          in   1       synchronous clear of pointers/occupancy/errors
//  wr_en          in   1       push request
//  wr_data        in   DATA_W  byte to push
//  rd_en          in   1       pop request
//  rd_data        out  DATA_W  popped byte, registered
//  rd_valid       out  1       rd_data holds a byte popped on previous cycle
//  occupancy      out  CNT_W   entries currently stored, 0..DEPTH
//  full           out  1       occupancy == DEPTH
//  empty          out  1       occupancy == 0
//  overflow_err   out  1       sticky: push rejected while full
//  underflow_err  out  1       sticky: pop rejected while empty
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, occupancy=0, rd_data=0, rd_valid=0, errors=0.
//    Resulting flags: empty=1, full=0. Memory contents are not cleared.
//  - Priority per cycle: rst > flush > push/pop.
//    flush has the same effect as reset except rd_data holds its value; rd_valid=0.
//  - Push accepted iff wr_en && (!full || rd_en_accepted).
//    Accepted push: mem[wr_ptr]<=wr_data; wr_ptr wraps DEPTH-1 -> 0.
//  - Pop accepted iff rd_en && !empty; a same-cycle push does not count.
//    Accepted pop: rd_data<=mem[rd_ptr]; rd_valid<=1 next cycle; rd_ptr wraps DEPTH-1 -> 0.
//    Not accepted: rd_valid<=0, rd_data holds.
//  - Read latency: 1 cycle from accepted rd_en to rd_valid/rd_data.
//  - Occupancy update:
//      push only      -> +1
//      pop only       -> -1
//      both accepted  -> unchanged
//      neither        -> unchanged
//    Occupancy never wraps; saturation is prevented by the accept rules.
//  - full and empty are decoded combinationally from the occupancy register.
//  - Rejected push: overflow_err<=1. Rejected pop: underflow_err<=1. Both stick until rst or flush.
//  - Full + push + pop: both accepted, occupancy stays DEPTH, no error.
//  - Empty + push + pop: push accepted, pop rejected, underflow_err set, occupancy -> 1.
//  - Reset or flush during a burst: the operation in that cycle is discarded; no write occurs.
// STRUCTURE
//  - Shared package usb_buffer_pkg: DATA_W/DEPTH/CNT_W localparams, typedef buf_byte_t, typedef buf_cnt_t.
//  - One sub-module: usb_buffer_mem.
//    DEPTH x DATA_W register array, 1 write port, 1 registered read port, no reset on storage.
//  - Pointer, occupancy and flag logic stay in the top level.
// TESTING
//  1. After rst, push 0x01..0x03 on 3 cycles.
//     -> occupancy=3, empty=0. Then 3 pops: rd_data 0x01, 0x02, 0x03 each 1 cycle after rd_en; empty=1.
//  2. Push 64 bytes 0x00..0x3F.
//     -> full=1, occupancy=64. 65th push (0xAA) -> overflow_err=1, occupancy=64.
//     Draining yields 0x00..0x3F; 0xAA is never seen.
//  3. At full, wr_en=rd_en=1 with 0x55 for 1 cycle.
//     -> occupancy=64, no error, rd_data=0x00. The 0x55 is popped last.
//  4. Empty, wr_en=rd_en=1 with 0x77.
//     -> underflow_err=1, rd_valid=0, occupancy=1. Next pop returns 0x77.
//  5. Push 10 bytes, pop 4, flush.
//     -> occupancy=0, empty=1, errors=0. Next push 0x9C then pop returns 0x9C (pointers back at 0).
//  6. Wrap: push/pop 100 bytes, keeping occupancy at 1..5.
//     -> data order preserved across pointer wrap. Then rst mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/usb_buffer_pkg.sv
// Shared types and sizing for the USB packet-path byte buffer.
package usb_buffer_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] buf_byte_t;
    typedef logic [CNT_W-1:0]  buf_cnt_t;
    typedef logic [PTR_W-1:0]  buf_ptr_t;

    localparam buf_cnt_t CNT_ZERO = buf_cnt_t'(0);
    localparam buf_cnt_t CNT_ONE  = buf_cnt_t'(1);
    localparam buf_cnt_t CNT_FULL = buf_cnt_t'(DEPTH);
    localparam buf_ptr_t PTR_ZERO = buf_ptr_t'(0);

    // DEPTH is a power of two, so the natural pointer overflow is the wrap.
    function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
        return p + buf_ptr_t'(1);
    endfunction

endpackage

// File: rtl/usb_data_buffer_if.sv
// Producer/consumer handshake bundle of the USB data buffer.
interface usb_data_buffer_if;
    import usb_buffer_pkg::*;

    logic      flush;
    logic      wr_en;
    buf_byte_t wr_data;
    logic      rd_en;
    buf_byte_t rd_data;
    logic      rd_valid;
    buf_cnt_t  occupancy;
    logic      full;
    logic      empty;
    logic      overflow_err;
    logic      underflow_err;

    // Protocol side: drives requests, observes data and status.
    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, occupancy, full, empty,
               overflow_err, underflow_err
    );

    // Buffer side.
    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, occupancy, full, empty,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/usb_buffer_mem.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// Storage is never reset; only the read register is.
module usb_buffer_mem
    import usb_buffer_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  buf_ptr_t  waddr,
    input  buf_byte_t wdata,
    input  logic      re,
    input  buf_ptr_t  raddr,
    output buf_byte_t rd_data
);

    buf_byte_t mem_q [DEPTH];
    buf_byte_t rd_data_q;
    buf_byte_t rd_data_d;

    // Write port: one entry per accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read register loads on an accepted pop, otherwise holds its byte.
    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem_q[raddr];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Read register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= buf_byte_t'(0);
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/usb_data_buffer.sv
// 64-byte single-clock FIFO for the USB packet path. Pointers, occupancy,
// status flags and sticky errors live here; storage is in usb_buffer_mem.
module usb_data_buffer
    import usb_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    usb_data_buffer_if.slave   bus
);

    buf_ptr_t wr_ptr_q, wr_ptr_d;
    buf_ptr_t rd_ptr_q, rd_ptr_d;
    buf_cnt_t occ_q, occ_d;
    logic     rd_valid_q, rd_valid_d;
    logic     ovf_q, ovf_d;
    logic     unf_q, unf_d;

    logic     empty_s, full_s;
    logic     rd_acc_s, wr_acc_s;
    logic     mem_we_s, mem_re_s;
    buf_byte_t mem_rd_data_s;

    // Status decode and accept rules; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        empty_s  = (occ_q == CNT_ZERO);
        full_s   = (occ_q == CNT_FULL);
        rd_acc_s = bus.rd_en && !empty_s;
        wr_acc_s = bus.wr_en && (!full_s || rd_acc_s);
        // Flush discards whatever the cycle carried; reset is handled by the registers.
        mem_we_s = wr_acc_s && !bus.flush && !rst;
        mem_re_s = rd_acc_s && !bus.flush && !rst;
    end

    // Next-state for pointers, occupancy, read-valid and sticky errors.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        if (bus.flush) begin
            wr_ptr_d   = PTR_ZERO;
            rd_ptr_d   = PTR_ZERO;
            occ_d      = CNT_ZERO;
            rd_valid_d = 1'b0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d   = ptr_inc(rd_ptr_q);
                rd_valid_d = 1'b1;
            end else begin
                rd_ptr_d   = rd_ptr_q;
                rd_valid_d = 1'b0;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   occ_d = occ_q + CNT_ONE;
                2'b01:   occ_d = occ_q - CNT_ONE;
                default: occ_d = occ_q;
            endcase
            if (bus.wr_en && !wr_acc_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (bus.rd_en && !rd_acc_s) begin
                unf_d = 1'b1;
            end else begin
                unf_d = unf_q;
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            occ_q      <= CNT_ZERO;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    usb_buffer_mem u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we_s),
        .waddr   (wr_ptr_q),
        .wdata   (bus.wr_data),
        .re      (mem_re_s),
        .raddr   (rd_ptr_q),
        .rd_data (mem_rd_data_s)
    );

    assign bus.rd_data       = mem_rd_data_s;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.occupancy     = occ_q;
    assign bus.full          = full_s;
    assign bus.empty         = empty_s;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed bench for usb_data_buffer: a queue-based reference model checked
// every falling edge, plus literal expectations at key points.
module tb_usb_data_buffer;
    import usb_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_data_buffer_if bus ();
    usb_data_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_rd_data;
    logic       m_rd_valid;
    logic       m_ovf;
    logic       m_unf;
    bit         model_live = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance, applied with the inputs present at the clock edge.
    task automatic model_edge(input logic r, input logic f, input logic w,
                              input logic [7:0] d, input logic p);
        bit pop_ok, push_ok;
        if (r) begin
            q.delete(); m_rd_data = 8'h00; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (f) begin
            q.delete(); m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            pop_ok  = p && (q.size() > 0);
            push_ok = w && ((q.size() < 64) || pop_ok);
            if (pop_ok) begin
                m_rd_data  = q.pop_front();
                m_rd_valid = 1'b1;
            end else begin
                m_rd_valid = 1'b0;
            end
            if (w && !push_ok) m_ovf = 1'b1;
            if (p && !pop_ok)  m_unf = 1'b1;
            if (push_ok) q.push_back(d);
        end
    endtask

    // One clock cycle with the given inputs; inputs return to idle afterwards.
    task automatic step(input logic w, input logic [7:0] d, input logic p,
                        input logic f, input logic r);
        rst = r; bus.flush = f; bus.wr_en = w; bus.wr_data = d; bus.rd_en = p;
        @(posedge clk);
        model_edge(r, f, w, d, p);
        if (r) model_live = 1'b1;
        #1;
        rst = 1'b0; bus.flush = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = 8'h00;
    endtask

    task automatic push(input logic [7:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
    task automatic pop();                     step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); endtask

    // Compare process: every output against the model on the falling edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("occupancy",  int'(bus.occupancy), q.size());
            chk_bit("full",   bus.full,  q.size() == 64);
            chk_bit("empty",  bus.empty, q.size() == 0);
            chk_bit("rd_valid", bus.rd_valid, m_rd_valid);
            chk("rd_data",    int'(bus.rd_data), int'(m_rd_data));
            chk_bit("overflow_err",  bus.overflow_err,  m_ovf);
            chk_bit("underflow_err", bus.underflow_err, m_unf);
        end
    end

    initial begin
        bus.flush = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = 8'h00;
        m_rd_data = 8'h00; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("reset_occ", int'(bus.occupancy), 0);
        chk_bit("reset_empty", bus.empty, 1'b1);
        chk_bit("reset_full", bus.full, 1'b0);
        chk("reset_rd_data", int'(bus.rd_data), 0);

        // 1: three pushes, three pops
        push(8'h01); push(8'h02); push(8'h03);
        chk("t1_occ", int'(bus.occupancy), 3);
        chk_bit("t1_empty", bus.empty, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            pop();
            chk_bit("t1_valid", bus.rd_valid, 1'b1);
            chk("t1_data", int'(bus.rd_data), i);
        end
        chk_bit("t1_empty_after", bus.empty, 1'b1);

        // 2: fill, overflow, drain
        for (int i = 0; i < 64; i++) push(8'(i));
        chk_bit("t2_full", bus.full, 1'b1);
        chk("t2_occ", int'(bus.occupancy), 64);
        push(8'hAA);
        chk_bit("t2_ovf", bus.overflow_err, 1'b1);
        chk("t2_occ_ovf", int'(bus.occupancy), 64);
        for (int i = 0; i < 64; i++) begin
            pop();
            chk("t2_drain", int'(bus.rd_data), i);
        end
        chk_bit("t2_empty", bus.empty, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk_bit("t2_ovf_flushed", bus.overflow_err, 1'b0);

        // 3: simultaneous push/pop at full
        for (int i = 0; i < 64; i++) push(8'(i));
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("t3_occ", int'(bus.occupancy), 64);
        chk_bit("t3_ovf", bus.overflow_err, 1'b0);
        chk("t3_data", int'(bus.rd_data), 0);
        for (int i = 1; i < 64; i++) begin
            pop();
            chk("t3_drain", int'(bus.rd_data), i);
        end
        pop();
        chk("t3_last", int'(bus.rd_data), 8'h55);

        // 4: simultaneous push/pop while empty
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk_bit("t4_unf", bus.underflow_err, 1'b1);
        chk_bit("t4_valid", bus.rd_valid, 1'b0);
        chk("t4_occ", int'(bus.occupancy), 1);
        pop();
        chk("t4_data", int'(bus.rd_data), 8'h77);

        // 5: partial traffic then flush; rd_data holds across flush
        for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
        for (int i = 0; i < 4; i++) pop();
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        chk("t5_occ", int'(bus.occupancy), 0);
        chk_bit("t5_empty", bus.empty, 1'b1);
        chk_bit("t5_unf", bus.underflow_err, 1'b0);
        chk_bit("t5_ovf", bus.overflow_err, 1'b0);
        chk_bit("t5_valid", bus.rd_valid, 1'b0);
        chk("t5_hold", int'(bus.rd_data), 8'h13);
        push(8'h9C);
        pop();
        chk("t5_data", int'(bus.rd_data), 8'h9C);

        // 6: 100 bytes through a shallow window, crossing the pointer wrap
        for (int i = 0; i < 3; i++) push(8'(i));
        for (int i = 3; i < 100; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            chk("t6_data", int'(bus.rd_data), i - 3);
        end
        for (int i = 97; i < 100; i++) begin
            pop();
            chk("t6_tail", int'(bus.rd_data), i);
        end
        push(8'hC1); push(8'hC2); pop(); pop(); pop();
        step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1);
        chk("t6_rst_occ", int'(bus.occupancy), 0);
        chk_bit("t6_rst_empty", bus.empty, 1'b1);
        chk_bit("t6_rst_full", bus.full, 1'b0);
        chk_bit("t6_rst_valid", bus.rd_valid, 1'b0);
        chk("t6_rst_data", int'(bus.rd_data), 0);
        chk_bit("t6_rst_unf", bus.underflow_err, 1'b0);
        chk_bit("t6_rst_ovf", bus.overflow_err, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
